// File: rtl/rnd_batch_buffer.sv
// Collects W-bit random words into a BATCH-bit batch for parallel DOM AND gadgets.
// Each accepted bit reaches at most one batch, and each batch can be consumed at most once.
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module rnd_batch_buffer #(
  parameter int d         = `DEFAULTSHARES,
  parameter int N_GADGETS = 20,
  parameter int W         = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [W-1:0]                   in_rnd,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [N_GADGETS*d*(d-1)/2-1:0] rnd_out,
  output logic                           rnd_valid,
  input  logic                           rnd_consume,
  output logic                           err_reuse
);
  localparam int BATCH = N_GADGETS*d*(d-1)/2;
  localparam int K     = (BATCH + W - 1) / W;
  localparam int CW    = $clog2(K + 1);

  logic [K*W-1:0]   fill_q, fill_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BATCH-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic             accept, xfer;

  assign in_ready  = (cnt_q < CW'(K));
  assign accept    = in_valid & in_ready;
  // A full fill register moves out whenever the output slot is free or being freed.
  assign xfer      = (cnt_q == CW'(K)) & (~vld_q | rnd_consume);
  assign rnd_out   = out_q;
  assign rnd_valid = vld_q;
  assign err_reuse = err_q;

  always_comb begin
    fill_d = fill_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    vld_d  = vld_q;
    err_d  = err_q;
    if (accept) begin
      for (int i = 0; i < K; i++)
        if (cnt_q == CW'(i)) fill_d[i*W +: W] = in_rnd;
      cnt_d = cnt_q + CW'(1);
    end
    if (rnd_consume & ~vld_q) err_d = 1'b1;
    if (xfer) begin
      out_d = fill_q[BATCH-1:0];
      vld_d = 1'b1;
      cnt_d = '0;
    end else if (rnd_consume & vld_q) begin
      out_d = '0;
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
    end
  end
endmodule

// File: tb/tb_rnd_batch_buffer.sv
// Directed bench for rnd_batch_buffer: vector table plus a streaming sequence.
module tb_rnd_batch_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_rnd = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] rnd_out;
  logic        rnd_valid;
  logic        rnd_consume = 1'b0;
  logic        err_reuse;

  int checks = 0;
  int failures = 0;

  rnd_batch_buffer dut (
    .clk(clk), .rst(rst), .in_rnd(in_rnd), .in_valid(in_valid), .in_ready(in_ready),
    .rnd_out(rnd_out), .rnd_valid(rnd_valid), .rnd_consume(rnd_consume), .err_reuse(err_reuse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [7:0]  din;
    logic        cons;
    logic        rdy;
    logic        vld;
    logic [19:0] out;
    logic        err;
  } vec_t;

  localparam int NV = 22;
  vec_t tv[NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic r, input logic iv, input logic [7:0] dn,
                      input logic c, input logic rdy, input logic vld,
                      input logic [19:0] o, input logic e);
    tv[i].rst = r; tv[i].iv = iv; tv[i].din = dn; tv[i].cons = c;
    tv[i].rdy = rdy; tv[i].vld = vld; tv[i].out = o; tv[i].err = e;
  endtask

  logic [7:0]  wq[$];
  logic [19:0] bq[$];
  logic [19:0] expb;
  logic [7:0]  w0, w1, w2;
  logic [7:0]  word;
  int          nb;

  initial begin
    //      i  rst iv din   cons  rdy vld out       err
    setv(0,  1, 0, 8'h00, 0,    1,  0, 20'h0,     0); // reset; ready right after
    setv(1,  0, 1, 8'hA1, 0,    1,  0, 20'h0,     0);
    setv(2,  0, 1, 8'hB2, 0,    1,  0, 20'h0,     0);
    setv(3,  0, 1, 8'hC3, 0,    0,  0, 20'h0,     0);
    setv(4,  0, 0, 8'h00, 0,    1,  1, 20'h3B2A1, 0); // transfer, nibble C dropped
    setv(5,  0, 0, 8'h00, 0,    1,  1, 20'h3B2A1, 0);
    setv(6,  0, 1, 8'h11, 0,    1,  1, 20'h3B2A1, 0);
    setv(7,  0, 1, 8'h22, 0,    1,  1, 20'h3B2A1, 0);
    setv(8,  0, 1, 8'h33, 0,    0,  1, 20'h3B2A1, 0);
    setv(9,  0, 1, 8'h44, 0,    0,  1, 20'h3B2A1, 0); // backpressure, word refused
    setv(10, 0, 1, 8'h55, 1,    1,  1, 20'h32211, 0); // consume + transfer, no bubble
    setv(11, 0, 1, 8'h66, 0,    1,  1, 20'h32211, 0);
    setv(12, 0, 0, 8'h00, 1,    1,  0, 20'h0,     0); // plain consume, cnt stays 1
    setv(13, 0, 0, 8'h00, 1,    1,  0, 20'h0,     1); // reuse error
    setv(14, 0, 0, 8'h00, 0,    1,  0, 20'h0,     1);
    setv(15, 0, 1, 8'h77, 0,    1,  0, 20'h0,     1); // cnt 2 (66,77)
    setv(16, 1, 1, 8'h88, 0,    1,  0, 20'h0,     0); // reset mid-fill wins
    setv(17, 0, 1, 8'h01, 0,    1,  0, 20'h0,     0);
    setv(18, 0, 1, 8'h02, 0,    1,  0, 20'h0,     0);
    setv(19, 0, 1, 8'h03, 0,    0,  0, 20'h0,     0);
    setv(20, 0, 0, 8'h00, 0,    1,  1, 20'h30201, 0); // no earlier bits
    setv(21, 0, 0, 8'h00, 1,    1,  0, 20'h0,     0);

    #1;
    for (int i = 0; i < NV; i++) begin
      rst = tv[i].rst; in_valid = tv[i].iv; in_rnd = tv[i].din; rnd_consume = tv[i].cons;
      step();
      chk($sformatf("v%0d.ready", i), 32'(in_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d.valid", i), 32'(rnd_valid), 32'(tv[i].vld));
      chk($sformatf("v%0d.out", i), 32'(rnd_out), 32'(tv[i].out));
      chk($sformatf("v%0d.err", i), 32'(err_reuse), 32'(tv[i].err));
    end

    // Streaming: counting words, consume whatever is presented.
    rst = 1'b1; in_valid = 1'b0; rnd_consume = 1'b0;
    step();
    rst = 1'b0;
    nb = 0;
    word = 8'h10;
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1;
      in_rnd = word;
      rnd_consume = rnd_valid;
      if (rnd_valid) begin
        expb = (bq.size() > 0) ? bq.pop_front() : 20'hxxxxx;
        chk($sformatf("stream.batch%0d", nb), 32'(rnd_out), 32'(expb));
        nb++;
      end
      if (in_ready) begin
        wq.push_back(word);
        word = word + 8'h1;
        if (wq.size() == 3) begin
          w0 = wq.pop_front(); w1 = wq.pop_front(); w2 = wq.pop_front();
          bq.push_back({w2[3:0], w1, w0});
        end
      end
      step();
    end
    in_valid = 1'b0;
    rnd_consume = 1'b0;
    if (rnd_valid) begin
      expb = (bq.size() > 0) ? bq.pop_front() : 20'hxxxxx;
      chk($sformatf("stream.batch%0d", nb), 32'(rnd_out), 32'(expb));
      nb++;
    end
    chk("stream.count", 32'(nb), 32'd10);
    chk("stream.err", 32'(err_reuse), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
